// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch/decode slice: opcodes, fetch FSM
// encoding, PC step and the branch-offset helper.
package mips_pkg;

   // Primary opcode field values (instr[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;

   // Sequential PC increment (one 32-bit word)
   localparam logic [31:0] PC_STEP = 32'd4;

   // Fetch FSM: IDLE after reset, REQ while memory is asked, HOLD while the
   // captured instruction waits for the decoder
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      HOLD = 2'b10
   } fetch_state_t;

   // Sign-extended, word-scaled branch displacement from the 16-bit immediate
   function automatic logic [31:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

   // Pseudo-direct jump target: upper nibble of pc+4, 26-bit index, word-aligned
   function automatic logic [31:0] jump_target(input logic [31:0] pcplus4,
                                               input logic [25:0] index);
      return {pcplus4[31:28], index, 2'b00};
   endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump beats taken branch beats sequential.
module next_pc_calc
   import mips_pkg::*;
(
   input  logic [31:0] instr,
   input  logic [31:0] pcplus4,
   input  logic        branch,
   input  logic        jump,
   input  logic        zero,
   output logic [31:0] next_pc
);

   // Opcode bits are decoded upstream; only the immediate/index fields matter here
   logic unused_opcode;
   assign unused_opcode = ^instr[31:26];

   logic [31:0] branch_target;
   logic [31:0] jmp_target;

   assign branch_target = pcplus4 + branch_offset(instr[15:0]);
   assign jmp_target    = jump_target(pcplus4, instr[25:0]);

   // Priority select of the following PC
   always_comb begin
      next_pc = pcplus4;
      if (jump) begin
         next_pc = jmp_target;
      end else if (branch && zero) begin
         next_pc = branch_target;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, memory req/ack handshake, instruction register
// with valid/ready handoff to the decoder, next-PC update and retired count.
module instr_fetch
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned CNT_W    = 32
)(
   input  logic             clk,
   input  logic             reset,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_ack,
   input  logic [31:0]      imem_rdata,
   output logic [31:0]      instr,
   output logic [5:0]       op,
   output logic             instr_valid,
   input  logic             instr_ready,
   input  logic             branch,
   input  logic             jump,
   input  logic             zero,
   output logic [31:0]      pc,
   output logic [31:0]      pcplus4,
   output logic [CNT_W-1:0] fetch_count
);

   fetch_state_t state;
   fetch_state_t state_n;

   logic        capture;   // memory word taken into the IR this edge
   logic        accept;    // decoder consumes the IR this edge
   logic [31:0] next_pc;

   assign pcplus4   = pc + PC_STEP;
   assign imem_addr = pc;
   assign op        = instr[31:26];

   next_pc_calc u_next_pc (
      .instr   (instr),
      .pcplus4 (pcplus4),
      .branch  (branch),
      .jump    (jump),
      .zero    (zero),
      .next_pc (next_pc)
   );

   // State register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state logic: one instruction in flight, never overlapping a held one
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = REQ;
         REQ:     if (imem_ack)    state_n = HOLD;
         HOLD:    if (instr_ready) state_n = REQ;
         default: state_n = IDLE;
      endcase
   end

   // Moore outputs plus the per-state handshake qualifiers; ack outside REQ is ignored
   always_comb begin
      imem_req    = (state == REQ);
      instr_valid = (state == HOLD);
      capture     = (state == REQ)  && imem_ack;
      accept      = (state == HOLD) && instr_ready;
   end

   // Datapath: IR capture, PC advance and retired-fetch count
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc          <= RESET_PC;
         instr       <= '0;
         fetch_count <= '0;
      end else begin
         if (capture) begin
            instr <= imem_rdata;
         end
         if (accept) begin
            pc          <= next_pc;
            fetch_count <= fetch_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [5:0]  op;
   logic        instr_valid;
   logic        instr_ready;
   logic        branch;
   logic        jump;
   logic        zero;
   logic [31:0] pc;
   logic [31:0] pcplus4;
   logic [31:0] fetch_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   instr_fetch #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .op          (op),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .branch      (branch),
      .jump        (jump),
      .zero        (zero),
      .pc          (pc),
      .pcplus4     (pcplus4),
      .fetch_count (fetch_count)
   );

   // Stimulus only: called at a negedge while in REQ; zero-wait ack, then accept.
   // Returns at the negedge after the accepting edge (DUT back in REQ).
   task automatic fetch_accept(input logic [31:0] word, input logic br,
                               input logic jp, input logic z);
      imem_ack = 1'b1; imem_rdata = word;
      @(negedge clk);
      imem_ack = 1'b0; instr_ready = 1'b1; branch = br; jump = jp; zero = z;
      @(negedge clk);
      instr_ready = 1'b0; branch = 1'b0; jump = 1'b0; zero = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 00000000", pc); end
      checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 00000000", instr); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
      checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fetch_count); end
      reset = 1'b1;
      @(negedge clk);
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b expected 1", imem_req); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr: got %h expected 00000000", imem_addr); end
      // two wait cycles with no ack: request must stay up at the same address
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wait_req: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr); end
      end
      imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
      @(negedge clk);
      imem_ack = 1'b0;
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL ack_valid: got %b expected 1", instr_valid); end
      checks++; if (instr !== 32'h2008_0005) begin errors++; $display("FAIL ack_instr: got %h expected 20080005", instr); end
      checks++; if (op !== 6'h08) begin errors++; $display("FAIL ack_op: got %h expected 08", op); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req: got %b expected 0", imem_req); end
      checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL hold_count: got %0d expected 0", fetch_count); end
   endtask

   task automatic test_sequential;
      instr_ready = 1'b1; branch = 1'b0; jump = 1'b0; zero = 1'b0;
      @(negedge clk);
      instr_ready = 1'b0;
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL seq_req: got %b expected 1", imem_req); end
      checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL seq_addr: got %h expected 00000004", imem_addr); end
      checks++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL seq_count: got %0d expected 1", fetch_count); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL seq_valid: got %b expected 0", instr_valid); end
      checks++; if (pcplus4 !== 32'h8) begin errors++; $display("FAIL seq_pcplus4: got %h expected 00000008", pcplus4); end
   endtask

   task automatic test_branch;
      // J index 4 from pc=4 -> 0x10
      fetch_accept(32'h0800_0004, 1'b0, 1'b1, 1'b0);
      checks++; if (pc !== 32'h10) begin errors++; $display("FAIL jmp_to_10: got %h expected 00000010", pc); end
      // BEQ imm -2 taken: 0x14 + (-8) = 0x0C
      fetch_accept(32'h1109_FFFE, 1'b1, 1'b0, 1'b1);
      checks++; if (pc !== 32'h0C) begin errors++; $display("FAIL beq_taken: got %h expected 0000000c", pc); end
      // J index 4 from pc=0xC -> 0x10 again
      fetch_accept(32'h0800_0004, 1'b0, 1'b1, 1'b0);
      // same BEQ with zero=0 falls through to 0x14
      fetch_accept(32'h1109_FFFE, 1'b1, 1'b0, 1'b0);
      checks++; if (pc !== 32'h14) begin errors++; $display("FAIL beq_not_taken: got %h expected 00000014", pc); end
   endtask

   task automatic test_jump;
      // J index 0x10 from pc=0x14 -> 0x40
      fetch_accept(32'h0800_0010, 1'b0, 1'b1, 1'b0);
      checks++; if (pc !== 32'h40) begin errors++; $display("FAIL jmp_to_40: got %h expected 00000040", pc); end
      // jump with branch&zero also high: jump wins -> 0x400
      fetch_accept(32'h0800_0100, 1'b1, 1'b1, 1'b1);
      checks++; if (pc !== 32'h400) begin errors++; $display("FAIL jmp_priority: got %h expected 00000400", pc); end
   endtask

   task automatic test_backpressure;
      imem_ack = 1'b1; imem_rdata = 32'h8C41_0008;
      @(negedge clk);
      imem_rdata = 32'hDEAD_BEEF;
      for (int i = 0; i < 5; i++) begin
         imem_ack = ~imem_ack;
         @(negedge clk);
         checks++; if (instr !== 32'h8C41_0008 || pc !== 32'h400 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
            errors++; $display("FAIL stall_%0d: got instr=%h pc=%h valid=%b req=%b expected instr=8c410008 pc=00000400 valid=1 req=0", i, instr, pc, instr_valid, imem_req);
         end
      end
      imem_ack = 1'b0; instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      checks++; if (pc !== 32'h404) begin errors++; $display("FAIL stall_release_pc: got %h expected 00000404", pc); end
      checks++; if (fetch_count !== 32'd8) begin errors++; $display("FAIL stall_release_count: got %0d expected 8", fetch_count); end
   endtask

   task automatic test_wrap;
      // J index 0 -> 0x0, then BEQ imm -2 taken from pc=0: 4 - 8 = 0xFFFFFFFC
      fetch_accept(32'h0800_0000, 1'b0, 1'b1, 1'b0);
      fetch_accept(32'h1000_FFFE, 1'b1, 1'b0, 1'b1);
      checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc: got %h expected fffffffc", pc); end
      checks++; if (pcplus4 !== 32'h0) begin errors++; $display("FAIL wrap_pcplus4: got %h expected 00000000", pcplus4); end
      fetch_accept(32'h0000_0020, 1'b0, 1'b0, 1'b0);
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_seq: got %h expected 00000000", pc); end
      checks++; if (fetch_count !== 32'd11) begin errors++; $display("FAIL wrap_count: got %0d expected 11", fetch_count); end
   endtask

   task automatic test_reset_midreq;
      // advance to a non-reset pc first so reset has visible effect
      fetch_accept(32'h0000_0020, 1'b0, 1'b0, 1'b0);
      checks++; if (imem_req !== 1'b1 || pc !== 32'h4) begin errors++; $display("FAIL pre_reset: got req=%b pc=%h expected req=1 pc=00000004", imem_req, pc); end
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; reset = 1'b0;
      @(negedge clk);
      imem_ack = 1'b0;
      checks++; if (instr !== 32'h0) begin errors++; $display("FAIL midreq_instr: got %h expected 00000000", instr); end
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL midreq_pc: got %h expected 00000000", pc); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL midreq_valid: got %b expected 0", instr_valid); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL midreq_req: got %b expected 0", imem_req); end
      checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL midreq_count: got %0d expected 0", fetch_count); end
      reset = 1'b1;
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rerelease: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr); end
   endtask

   initial begin
      reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
      branch = 1'b0; jump = 1'b0; zero = 1'b0;
      @(negedge clk);
      test_reset;
      test_sequential;
      test_branch;
      test_jump;
      test_backpressure;
      test_wrap;
      test_reset_midreq;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete within 100000 time units");
      $fatal(1, "timeout");
   end

endmodule
